// File: rtl/instr_type.sv
// Shared decode/execute types for the fence path: fence kinds, the fence
// sequencer states and the fetch offset used for the FENCE.I redirect.
package instr_type;

  typedef enum logic [1:0] {
    fk_invalid = 2'd0,
    fk_fence   = 2'd1,
    fk_fence_i = 2'd2
  } fence_kind_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    INV_REQ = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } fence_state_t;

  localparam int FENCE_NEXT_PC_OFFSET = 4;

endpackage

// File: rtl/fence_unit_if.sv
// Issue, LSU drain, icache invalidate and redirect signals of the fence unit.
// slave is the fence unit's view, master the surrounding pipeline's view.
interface fence_unit_if
  import instr_type::*;
#(
  parameter int XLEN = 32
);
  logic            valid_i;
  fence_kind_t     kind;
  logic [XLEN-1:0] pc;
  logic [3:0]      pred;
  logic [3:0]      succ;
  logic            ready_o;
  logic            busy_o;
  logic            sb_empty;
  logic            lsu_idle;
  logic            drain_req;
  logic            ic_inv_req;
  logic            ic_inv_ack;
  logic            flush_o;
  logic [XLEN-1:0] redirect_pc;
  logic            done_o;
  logic            illegal_o;
  logic            timeout_o;

  modport slave (
    input  valid_i, kind, pc, pred, succ, sb_empty, lsu_idle, ic_inv_ack,
    output ready_o, busy_o, drain_req, ic_inv_req, flush_o, redirect_pc,
           done_o, illegal_o, timeout_o
  );

  modport master (
    output valid_i, kind, pc, pred, succ, sb_empty, lsu_idle, ic_inv_ack,
    input  ready_o, busy_o, drain_req, ic_inv_req, flush_o, redirect_pc,
           done_o, illegal_o, timeout_o
  );
endinterface

// File: rtl/fence_unit_watchdog.sv
// Drain/invalidate watchdog for the fence unit; the module exists only when
// FENCE_TIMEOUT_EN is defined, matching the single place it is instantiated.
`ifdef FENCE_TIMEOUT_EN
module fence_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic restart,
  output logic fire,
  output logic timeout
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Fires during the last allowed waiting cycle so the FSM leaves on the
  // edge that completes TIMEOUT_CYCLES cycles of waiting.
  assign fire = active && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      if (restart) begin
        cnt_q <= '0;
      end else if (active) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (fire) begin
        timeout <= 1'b1;
      end
    end
  end
endmodule
`endif

// File: rtl/fence_unit.sv
// Execute-side FENCE / FENCE.I sequencer: drains LSU, invalidates icache,
// flushes and redirects. Optional watchdog enabled by FENCE_TIMEOUT_EN.
module fence_unit
  import instr_type::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic         clk,
  input logic         rst,
  fence_unit_if.slave fif
);

  fence_state_t    state_q, state_d;
  fence_kind_t     kind_q;
  logic [XLEN-1:0] pc_q;
  logic            accept;
  logic            wd_fire;
  logic            timeout_w;
  logic            drain_d, inv_d, flush_d, done_d, illegal_d;
  logic            drain_q, inv_q, flush_q, done_q, illegal_q;
  logic [XLEN-1:0] redirect_q;

  assign accept = (state_q == IDLE) && fif.valid_i;

`ifdef FENCE_TIMEOUT_EN
  logic wd_active, wd_restart;

  assign wd_active  = (state_q == DRAIN) || (state_q == INV_REQ);
  assign wd_restart = ((state_d == DRAIN) || (state_d == INV_REQ)) &&
                      (state_d != state_q);

  fence_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active (wd_active),
    .restart(wd_restart),
    .fire   (wd_fire),
    .timeout(timeout_w)
  );
`else
  assign wd_fire   = 1'b0;
  assign timeout_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      kind_q     <= fk_invalid;
      pc_q       <= '0;
      drain_q    <= 1'b0;
      inv_q      <= 1'b0;
      flush_q    <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      redirect_q <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      inv_q     <= inv_d;
      flush_q   <= flush_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      if (accept) begin
        kind_q <= fif.kind;
        pc_q   <= fif.pc;
      end
      if (state_q == FLUSH) begin
        redirect_q <= pc_q + XLEN'(FENCE_NEXT_PC_OFFSET);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (fif.kind)
            fk_fence:   state_d = ((fif.pred == 4'd0) || (fif.succ == 4'd0)) ? DONE : DRAIN;
            fk_fence_i: state_d = DRAIN;
            default:    state_d = IDLE;
          endcase
        end
      end
      DRAIN: begin
        if (fif.sb_empty && fif.lsu_idle) begin
          state_d = (kind_q == fk_fence_i) ? INV_REQ : DONE;
        end
      end
      INV_REQ: begin
        if (fif.ic_inv_ack) begin
          state_d = FLUSH;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wd_fire) begin
      state_d = DONE;
    end
  end

  // Requests follow the next state so they rise on entry and drop on exit;
  // pulses follow the current state, giving the fixed completion latencies.
  always_comb begin
    drain_d   = (state_d == DRAIN);
    inv_d     = (state_d == INV_REQ);
    flush_d   = (state_q == FLUSH);
    done_d    = (state_q == DONE);
    illegal_d = accept && (fif.kind != fk_fence) && (fif.kind != fk_fence_i);
  end

  assign fif.ready_o     = (state_q == IDLE);
  assign fif.busy_o      = (state_q != IDLE);
  assign fif.drain_req   = drain_q;
  assign fif.ic_inv_req  = inv_q;
  assign fif.flush_o     = flush_q;
  assign fif.redirect_pc = redirect_q;
  assign fif.done_o      = done_q;
  assign fif.illegal_o   = illegal_q;
  assign fif.timeout_o   = timeout_w;

endmodule

// File: tb/tb_fence_unit.sv
// Scoreboard bench for fence_unit: expected done/flush/illegal events are
// queued with their cycle when a fence is issued and matched against the DUT.
module tb_fence_unit;
  import instr_type::*;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fence_unit_if #(.XLEN(XLEN)) fif ();

  fence_unit #(
    .XLEN          (XLEN),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fif(fif)
  );

  typedef enum int {EV_DONE = 0, EV_FLUSH = 1, EV_ILLEGAL = 2} ev_t;
  typedef struct {
    ev_t         ev;
    int          cyc;
    logic [31:0] pc;
  } ev_s;

  ev_s exp_q[$];
  ev_s act_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  drain_cnt = 0;
  int  inv_cnt = 0;
  int  flush_cnt = 0;
  int  busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance to the next falling edge and record what the DUT shows there.
  task automatic tick();
    @(negedge clk);
    if (fif.flush_o)   act_q.push_back('{EV_FLUSH, cyc, fif.redirect_pc});
    if (fif.done_o)    act_q.push_back('{EV_DONE, cyc, 32'h0});
    if (fif.illegal_o) act_q.push_back('{EV_ILLEGAL, cyc, 32'h0});
    if (fif.flush_o)    flush_cnt++;
    if (fif.drain_req)  drain_cnt++;
    if (fif.ic_inv_req) inv_cnt++;
    if (fif.busy_o)     busy_cnt++;
  endtask

  task automatic issue(input fence_kind_t k, input logic [31:0] p,
                       input logic [3:0] pr, input logic [3:0] su, output int acc);
    fif.valid_i = 1'b1;
    fif.kind    = k;
    fif.pc      = p;
    fif.pred    = pr;
    fif.succ    = su;
    tick();
    acc = cyc;
    fif.valid_i = 1'b0;
  endtask

  task automatic settle(input int max);
    int n = 0;
    while ((act_q.size() < exp_q.size() || fif.busy_o) && n < max) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    fif.valid_i = 1'b0; fif.kind = fk_invalid; fif.pc = '0; fif.pred = '0; fif.succ = '0;
    fif.sb_empty = 1'b1; fif.lsu_idle = 1'b1; fif.ic_inv_ack = 1'b0;
    #1;
    total++;
    if (fif.ready_o !== 1'b1 || fif.busy_o !== 1'b0) begin
      bad++; $display("FAIL reset_ready_busy got=%b%b want=10", fif.ready_o, fif.busy_o);
    end
    total++;
    if ({fif.drain_req, fif.ic_inv_req, fif.flush_o, fif.done_o, fif.illegal_o, fif.timeout_o} !== 6'b0) begin
      bad++; $display("FAIL reset_outputs got=%b want=000000",
                      {fif.drain_req, fif.ic_inv_req, fif.flush_o, fif.done_o, fif.illegal_o, fif.timeout_o});
    end
    total++;
    if (fif.redirect_pc !== 32'h0) begin
      bad++; $display("FAIL reset_redirect got=%h want=00000000", fif.redirect_pc);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_noop_fence();
    int acc, d0;
    d0 = drain_cnt;
    issue(fk_fence, 32'h100, 4'b0000, 4'b1111, acc);
    exp_q.push_back('{EV_DONE, acc + 1, 32'h0});
    settle(20);
    while (exp_q.size() > 0) begin
      ev_s e, a;
      e = exp_q.pop_front();
      total++;
      if (act_q.size() == 0) begin
        bad++; $display("FAIL noop_event got=none want=ev%0d@%0d", e.ev, e.cyc);
      end else begin
        a = act_q.pop_front();
        if (a.ev !== e.ev || a.cyc !== e.cyc || a.pc !== e.pc) begin
          bad++; $display("FAIL noop_event got=ev%0d@%0d pc=%h want=ev%0d@%0d pc=%h", a.ev, a.cyc, a.pc, e.ev, e.cyc, e.pc);
        end
      end
    end
    total++;
    if (act_q.size() !== 0) begin
      bad++; $display("FAIL noop_extra got=%0d want=0", act_q.size()); act_q.delete();
    end
    total++;
    if (drain_cnt - d0 !== 0) begin
      bad++; $display("FAIL noop_drain got=%0d want=0", drain_cnt - d0);
    end
  endtask

  task automatic test_fence_drain();
    int acc, d0, f0;
    d0 = drain_cnt; f0 = flush_cnt;
    fif.sb_empty = 1'b0;
    issue(fk_fence, 32'h200, 4'b0011, 4'b0011, acc);
    exp_q.push_back('{EV_DONE, acc + 7, 32'h0});
    tick(); tick();
    total++;
    if (fif.busy_o !== 1'b1 || fif.ready_o !== 1'b0) begin
      bad++; $display("FAIL drain_busy got=%b%b want=10", fif.busy_o, fif.ready_o);
    end
    repeat (3) tick();
    fif.sb_empty = 1'b1;
    settle(30);
    while (exp_q.size() > 0) begin
      ev_s e, a;
      e = exp_q.pop_front();
      total++;
      if (act_q.size() == 0) begin
        bad++; $display("FAIL drain_event got=none want=ev%0d@%0d", e.ev, e.cyc);
      end else begin
        a = act_q.pop_front();
        if (a.ev !== e.ev || a.cyc !== e.cyc) begin
          bad++; $display("FAIL drain_event got=ev%0d@%0d want=ev%0d@%0d", a.ev, a.cyc, e.ev, e.cyc);
        end
      end
    end
    total++;
    if (act_q.size() !== 0) begin
      bad++; $display("FAIL drain_extra got=%0d want=0", act_q.size()); act_q.delete();
    end
    total++;
    if (drain_cnt - d0 !== 6) begin
      bad++; $display("FAIL drain_req_cycles got=%0d want=6", drain_cnt - d0);
    end
    total++;
    if (flush_cnt - f0 !== 0) begin
      bad++; $display("FAIL drain_flush got=%0d want=0", flush_cnt - f0);
    end
  endtask

  // ack_at: the edge after acceptance (>=2) at which ic_inv_ack is sampled high.
  task automatic run_fence_i(input logic [31:0] p, input int ack_at, input string name);
    int acc, i0;
    logic [31:0] tgt;
    i0 = inv_cnt;
    tgt = p + 32'd4;
    issue(fk_fence_i, p, 4'b0000, 4'b0000, acc);
    exp_q.push_back('{EV_FLUSH, acc + ack_at + 1, tgt});
    exp_q.push_back('{EV_DONE, acc + ack_at + 2, 32'h0});
    repeat (ack_at - 1) tick();
    fif.ic_inv_ack = 1'b1;
    tick();
    fif.ic_inv_ack = 1'b0;
    settle(30);
    while (exp_q.size() > 0) begin
      ev_s e, a;
      e = exp_q.pop_front();
      total++;
      if (act_q.size() == 0) begin
        bad++; $display("FAIL %s_event got=none want=ev%0d@%0d", name, e.ev, e.cyc);
      end else begin
        a = act_q.pop_front();
        if (a.ev !== e.ev || a.cyc !== e.cyc || a.pc !== e.pc) begin
          bad++; $display("FAIL %s_event got=ev%0d@%0d pc=%h want=ev%0d@%0d pc=%h", name, a.ev, a.cyc, a.pc, e.ev, e.cyc, e.pc);
        end
      end
    end
    total++;
    if (act_q.size() !== 0) begin
      bad++; $display("FAIL %s_extra got=%0d want=0", name, act_q.size()); act_q.delete();
    end
    total++;
    if (inv_cnt - i0 !== ack_at - 1) begin
      bad++; $display("FAIL %s_inv_cycles got=%0d want=%0d", name, inv_cnt - i0, ack_at - 1);
    end
  endtask

  task automatic test_fence_i();
    run_fence_i(32'h0000_1000, 4, "fence_i");
  endtask

  task automatic test_fence_i_wrap();
    run_fence_i(32'hFFFF_FFFC, 2, "fence_i_wrap");
  endtask

  task automatic test_reset_mid();
    int acc, i0;
    fif.sb_empty = 1'b0;
    issue(fk_fence, 32'h300, 4'b1111, 4'b1111, acc);
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    total++;
    if (fif.ready_o !== 1'b1 || fif.busy_o !== 1'b0 || fif.drain_req !== 1'b0) begin
      bad++; $display("FAIL rst_mid_async got=%b%b%b want=100", fif.ready_o, fif.busy_o, fif.drain_req);
    end
    total++;
    if (fif.redirect_pc !== 32'h0) begin
      bad++; $display("FAIL rst_mid_redirect got=%h want=00000000", fif.redirect_pc);
    end
    tick();
    rst = 1'b1;
    fif.sb_empty = 1'b1;
    tick();
    i0 = inv_cnt;
    fif.ic_inv_ack = 1'b1;
    tick();
    fif.ic_inv_ack = 1'b0;
    repeat (4) tick();
    total++;
    if (fif.ready_o !== 1'b1 || inv_cnt - i0 !== 0 || act_q.size() !== 0) begin
      bad++; $display("FAIL rst_mid_stale_ack got=ready%b inv%0d ev%0d want=ready1 inv0 ev0",
                      fif.ready_o, inv_cnt - i0, act_q.size());
      act_q.delete();
    end
  endtask

  task automatic test_illegal();
    int acc, b0;
    b0 = busy_cnt;
    issue(fk_invalid, 32'h400, 4'b1111, 4'b1111, acc);
    exp_q.push_back('{EV_ILLEGAL, acc, 32'h0});
    settle(10);
    while (exp_q.size() > 0) begin
      ev_s e, a;
      e = exp_q.pop_front();
      total++;
      if (act_q.size() == 0) begin
        bad++; $display("FAIL illegal_event got=none want=ev%0d@%0d", e.ev, e.cyc);
      end else begin
        a = act_q.pop_front();
        if (a.ev !== e.ev || a.cyc !== e.cyc) begin
          bad++; $display("FAIL illegal_event got=ev%0d@%0d want=ev%0d@%0d", a.ev, a.cyc, e.ev, e.cyc);
        end
      end
    end
    total++;
    if (act_q.size() !== 0 || busy_cnt - b0 !== 0) begin
      bad++; $display("FAIL illegal_extra got=ev%0d busy%0d want=ev0 busy0", act_q.size(), busy_cnt - b0);
      act_q.delete();
    end
  endtask

`ifdef FENCE_TIMEOUT_EN
  task automatic test_timeout();
    int acc, d0;
    d0 = drain_cnt;
    fif.sb_empty = 1'b0;
    issue(fk_fence, 32'h500, 4'b0011, 4'b0011, acc);
    exp_q.push_back('{EV_DONE, acc + TO + 1, 32'h0});
    repeat (TO - 1) tick();
    total++;
    if (fif.timeout_o !== 1'b0) begin
      bad++; $display("FAIL timeout_early got=%b want=0", fif.timeout_o);
    end
    tick();
    total++;
    if (fif.timeout_o !== 1'b1 || drain_cnt - d0 !== TO) begin
      bad++; $display("FAIL timeout_rise got=%b drain%0d want=1 drain%0d", fif.timeout_o, drain_cnt - d0, TO);
    end
    settle(20);
    while (exp_q.size() > 0) begin
      ev_s e, a;
      e = exp_q.pop_front();
      total++;
      if (act_q.size() == 0) begin
        bad++; $display("FAIL timeout_event got=none want=ev%0d@%0d", e.ev, e.cyc);
      end else begin
        a = act_q.pop_front();
        if (a.ev !== e.ev || a.cyc !== e.cyc) begin
          bad++; $display("FAIL timeout_event got=ev%0d@%0d want=ev%0d@%0d", a.ev, a.cyc, e.ev, e.cyc);
        end
      end
    end
    total++;
    if (fif.timeout_o !== 1'b1 || fif.drain_req !== 1'b0) begin
      bad++; $display("FAIL timeout_sticky got=%b%b want=10", fif.timeout_o, fif.drain_req);
    end
    fif.sb_empty = 1'b1;
    rst = 1'b0;
    tick();
    total++;
    if (fif.timeout_o !== 1'b0) begin
      bad++; $display("FAIL timeout_clear got=%b want=0", fif.timeout_o);
    end
    rst = 1'b1;
    tick();
  endtask
`else
  task automatic test_timeout();
    int acc;
    fif.sb_empty = 1'b0;
    issue(fk_fence, 32'h500, 4'b0011, 4'b0011, acc);
    repeat (TO + 4) tick();
    total++;
    if (fif.timeout_o !== 1'b0 || fif.busy_o !== 1'b1) begin
      bad++; $display("FAIL timeout_off got=%b%b want=01", fif.timeout_o, fif.busy_o);
    end
    fif.sb_empty = 1'b1;
    settle(10);
    act_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_noop_fence();
    test_fence_drain();
    test_fence_i();
    test_reset_mid();
    test_fence_i_wrap();
    test_illegal();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fence_unit.md
Name: fence_unit

Overview:
- Execute-side sequencer for the fence kinds produced by the fence decoder (fence_kind_t from instr_type).
- FENCE: waits until the store buffer and LSU have drained.
- FENCE.I: drains, invalidates the instruction cache via a req/ack handshake, then flushes the pipeline and redirects fetch to pc+4.
- Sits between decode/issue and the LSU/icache/fetch-redirect logic.

Parameters:
- XLEN, 32, width of pc and redirect_pc.
- TIMEOUT_CYCLES, 1024, watchdog limit for drain/invalidate; used only with FENCE_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  issue offers a fence op.
- kind  in  fence_kind_t  decoded fence kind.
- pc  in  XLEN  pc of the fence instruction.
- pred  in  4  fence predecessor set (I,O,R,W).
- succ  in  4  fence successor set.
- ready_o  out  1  unit can accept; handshake when valid_i && ready_o.
- busy_o  out  1  op in flight; issue stalls younger memory ops.
- sb_empty  in  1  store buffer empty.
- lsu_idle  in  1  no outstanding loads/stores.
- drain_req  out  1  LSU must stop accepting new ops and drain.
- ic_inv_req  out  1  icache invalidate-all request.
- ic_inv_ack  in  1  icache invalidate done (single-cycle pulse).
- flush_o  out  1  one-cycle pipeline flush pulse.
- redirect_pc  out  XLEN  fetch target, valid with flush_o.
- done_o  out  1  one-cycle completion pulse (retire).
- illegal_o  out  1  one-cycle pulse: accepted op had kind fk_invalid.
- timeout_o  out  1  watchdog fired (only with FENCE_TIMEOUT_EN; else tied 0).

Behaviour:
- Reset (rst low, async):
  - state IDLE.
  - Outputs: ready_o=1; busy_o, drain_req, ic_inv_req, flush_o, done_o, illegal_o, timeout_o = 0; redirect_pc = 0.
  - Captured kind/pc cleared.
  - Reset mid-operation abandons the op; an ic_inv_ack arriving after reset is ignored.
- States: IDLE, DRAIN, INV_REQ, FLUSH, DONE.
  - ready_o = (state==IDLE).
  - busy_o = (state!=IDLE).
  - All other outputs are registered.
- Accept in IDLE on valid_i (kind, pc, pred, succ captured):
  - kind fk_invalid: illegal_o pulses next cycle, stay IDLE.
  - fk_fence with pred==0 or succ==0: no-op, go to DONE.
  - fk_fence otherwise: go to DRAIN.
  - fk_fence_i: go to DRAIN regardless of pred/succ.
- DRAIN:
  - drain_req=1.
  - Leave when sb_empty && lsu_idle in the same cycle.
  - fk_fence goes to DONE; fk_fence_i goes to INV_REQ.
  - drain_req deasserts on exit.
- INV_REQ:
  - ic_inv_req=1 held until the cycle after ic_inv_ack is sampled high, then go to FLUSH.
  - ic_inv_ack outside INV_REQ is ignored.
- FLUSH:
  - flush_o=1 for exactly one cycle.
  - redirect_pc = captured pc + 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0x00000000).
  - Next state DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Latency (accept at cycle N, inputs already idle/empty):
  - no-op FENCE: done_o at N+2.
  - FENCE: done_o at N+3.
  - FENCE.I with ack at first possible cycle: done_o at N+5.
- valid_i while busy is not accepted; the issuer must hold it.

Optional Feature:
- Macro: FENCE_TIMEOUT_EN.
- When defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to DRAIN/INV_REQ and increments each cycle in those states.
  - On reaching TIMEOUT_CYCLES: timeout_o=1 sticky until reset, and the FSM forces DONE so done_o still pulses.
  - drain_req and ic_inv_req drop.
- When not defined: no counter; timeout_o tied 0; the FSM waits indefinitely.

Decomposition:
- fence_state_t (enum of the 5 states) goes in instr_type beside fence_kind_t.
- Shared constant FENCE_NEXT_PC_OFFSET = 4 goes there too.
- Natural sub-module: fence_watchdog, holding the counter and sticky flag, instantiated only under FENCE_TIMEOUT_EN.

Test Plan:
- Reset asserted mid-DRAIN -> outputs return to reset values immediately (asynchronously); ready_o=1 after release; a stale ic_inv_ack pulse causes no output change.
- fk_fence, pred=4'b0011, succ=4'b0011, sb_empty=0 for 5 cycles then 1, lsu_idle=1 -> drain_req high 6 cycles; done_o once; flush_o never asserted.
- fk_fence, pred=0 -> done_o at N+2; drain_req never asserted.
- fk_fence_i, pc=0x00001000, ic_inv_ack pulsed 3 cycles into INV_REQ -> flush_o one cycle with redirect_pc=0x00001004, then done_o.
- fk_fence_i, pc=0xFFFFFFFC -> redirect_pc=0x00000000. Then fk_invalid -> illegal_o one pulse, busy_o stays 0.
- FENCE_TIMEOUT_EN, TIMEOUT_CYCLES=8, sb_empty held 0 -> timeout_o rises after 8 DRAIN cycles; done_o pulses; timeout_o remains high until reset.
